// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the RV64M divider front end:
//   - XLEN            : datapath width (64)
//   - div_state_e     : control FSM states IDLE / ISSUE / WAIT / DONE (2-bit)
//   - INT64_MIN       : most negative 64-bit value
//   - INT32_MIN_SEXT  : most negative 32-bit value sign-extended to 64 bits
//   - sext32()        : sign-extend a 32-bit value to XLEN
//   - format_result() : quotient/remainder select plus W-variant sign extension
package div_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  localparam logic [XLEN-1:0] INT64_MIN      = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] INT32_MIN_SEXT = 64'hFFFF_FFFF_8000_0000;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] value);
    return {{32{value[31]}}, value};
  endfunction

  // W results are always sign-extended from bit 31, even for DIVUW/REMUW,
  // because RV64 keeps every 32-bit result in canonical sign-extended form.
  function automatic logic [XLEN-1:0] format_result(
    input logic [XLEN-1:0] quotient,
    input logic [XLEN-1:0] remainder,
    input logic            is_rem,
    input logic            is_word
  );
    logic [XLEN-1:0] sel;
    sel = is_rem ? remainder : quotient;
    return is_word ? sext32(sel[31:0]) : sel;
  endfunction

endpackage

// File: rtl/div_operand_prep.sv
// div_operand_prep
// Combinational operand preparation for the divider front end.
// Ports:
//   rs1, rs2     in  : raw register operands (dividend, divisor)
//   is_unsigned  in  : DIVU/REMU family
//   is_word      in  : W variant, only the low 32 bits are significant
//   dividend     out : prepared dividend (extended for W ops)
//   divisor      out : prepared divisor (extended for W ops)
//   is_div_zero  out : prepared divisor is zero
//   is_overflow  out : signed most-negative / -1 overflow case
module div_operand_prep
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            is_unsigned,
  input  logic            is_word,
  output logic [XLEN-1:0] dividend,
  output logic [XLEN-1:0] divisor,
  output logic            is_div_zero,
  output logic            is_overflow
);

  logic [XLEN-1:0] min_value;

  // W operands are extended so the 64-bit divider yields the correct 32-bit
  // quotient and remainder; full-width operands pass straight through.
  always_comb begin
    dividend = rs1;
    divisor  = rs2;
    if (is_word) begin
      if (is_unsigned) begin
        dividend = {32'b0, rs1[31:0]};
        divisor  = {32'b0, rs2[31:0]};
      end else begin
        dividend = sext32(rs1[31:0]);
        divisor  = sext32(rs2[31:0]);
      end
    end
  end

  // Special cases are detected on the prepared operands, so a W overflow
  // compares against the sign-extended 32-bit minimum.
  assign min_value   = is_word ? INT32_MIN_SEXT : INT64_MIN;
  assign is_div_zero = (divisor == '0);
  assign is_overflow = ~is_unsigned & (divisor == '1) & (dividend == min_value);

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
// Front end and result formatter for the iterative 64-bit divider in the
// RV64M execute path. One operation in flight at a time.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   flush                         : kill any in-flight operation
//   in_valid/in_ready             : request handshake from issue
//   in_rs1, in_rs2                : raw dividend / divisor
//   in_is_rem, in_is_unsigned,
//   in_is_word, in_tag            : operation flavour and destination tag
//   out_valid/out_ready           : result handshake to writeback
//   out_result, out_tag           : formatted result and its tag
//   div_valid, div_signed,
//   div_dividend, div_divisor     : request to the divider
//   div_flush                     : abort to the divider
//   div_o_valid/div_o_ready       : divider completion handshake
//   div_quotient, div_remainder   : divider outputs
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic             in_is_rem,
  input  logic             in_is_unsigned,
  input  logic             in_is_word,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_valid,
  output logic             div_signed,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  output logic             div_flush,
  input  logic             div_o_valid,
  output logic             div_o_ready,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder
);

  div_state_e state_q, state_d;

  logic [XLEN-1:0]  prep_dividend;
  logic [XLEN-1:0]  prep_divisor;
  logic             is_div_zero;
  logic             is_overflow;
  logic             is_special;
  logic [XLEN-1:0]  special_result;

  logic             accept;
  logic             div_done;

  logic             signed_q;
  logic [XLEN-1:0]  dividend_q;
  logic [XLEN-1:0]  divisor_q;
  logic             is_rem_q;
  logic             is_word_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] result_tag_q;

  div_operand_prep u_prep (
    .rs1         (in_rs1),
    .rs2         (in_rs2),
    .is_unsigned (in_is_unsigned),
    .is_word     (in_is_word),
    .dividend    (prep_dividend),
    .divisor     (prep_divisor),
    .is_div_zero (is_div_zero),
    .is_overflow (is_overflow)
  );

  // Divide-by-zero and signed overflow have architecturally fixed results,
  // so they are answered here without occupying the divider.
  assign is_special     = is_div_zero | is_overflow;
  assign special_result = is_div_zero
                        ? format_result('1, prep_dividend, in_is_rem, in_is_word)
                        : format_result(prep_dividend, '0, in_is_rem, in_is_word);

  // Handshake outputs; flush gates every request/accept toward the divider.
  assign in_ready    = (state_q == IDLE) & ~flush;
  assign accept      = in_valid & in_ready;
  assign div_valid   = (state_q == ISSUE) & ~flush;
  assign div_o_ready = (state_q == WAIT) & ~flush;
  assign div_done    = div_o_valid & div_o_ready;
  assign div_flush   = flush & (state_q != IDLE);
  assign out_valid   = (state_q == DONE);

  assign div_signed   = signed_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign out_result   = result_q;
  assign out_tag      = result_tag_q;

  // Next-state logic. Flush overrides every transition, including a divider
  // completion in the same cycle, which is thereby discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_special ? DONE : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (div_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State, operand and result registers. The prepared operands are only
  // rewritten on acceptance so they stay stable through the completion
  // handshake, where the divider re-reads them for sign correction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      signed_q     <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      is_rem_q     <= 1'b0;
      is_word_q    <= 1'b0;
      tag_q        <= '0;
      result_q     <= '0;
      result_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        signed_q   <= ~in_is_unsigned;
        dividend_q <= prep_dividend;
        divisor_q  <= prep_divisor;
        is_rem_q   <= in_is_rem;
        is_word_q  <= in_is_word;
        tag_q      <= in_tag;
        if (is_special) begin
          result_q     <= special_result;
          result_tag_q <= in_tag;
        end
      end
      if (div_done) begin
        result_q     <= format_result(div_quotient, div_remainder, is_rem_q, is_word_q);
        result_tag_q <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl
// Scoreboard bench for div_issue_ctrl: directed operations push their
// hand-computed results into a queue, a monitor pops and compares on every
// writeback handshake, and a small behavioural divider answers requests.
module tb_div_issue_ctrl;

  localparam int TAG_W = 5;

  typedef struct packed {
    logic [63:0]      result;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_rs1;
  logic [63:0]      in_rs2;
  logic             in_is_rem;
  logic             in_is_unsigned;
  logic             in_is_word;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             div_valid;
  logic             div_signed;
  logic [63:0]      div_dividend;
  logic [63:0]      div_divisor;
  logic             div_flush;
  logic             div_o_valid;
  logic             div_o_ready;
  logic [63:0]      div_quotient;
  logic [63:0]      div_remainder;

  int   checks = 0;
  int   errors = 0;
  int   div_valid_pulses = 0;
  int   div_latency = 3;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_is_rem      (in_is_rem),
    .in_is_unsigned (in_is_unsigned),
    .in_is_word     (in_is_word),
    .in_tag         (in_tag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_tag        (out_tag),
    .div_valid      (div_valid),
    .div_signed     (div_signed),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_flush      (div_flush),
    .div_o_valid    (div_o_valid),
    .div_o_ready    (div_o_ready),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: compares every accepted writeback against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (div_valid === 1'b1) div_valid_pulses++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got result %h tag %0d expected no output",
                 out_result, out_tag);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_result", out_result, e.result);
        checkOutput("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  // Behavioural divider: samples at negedge, updates just after posedge.
  logic [63:0] m_a, m_b;
  logic        m_signed;
  logic        m_busy;
  int          m_count;
  logic        fire_s, kill_s, start_s;

  always begin : divider_model
    @(negedge clk);
    fire_s  = div_o_valid & div_o_ready;
    kill_s  = div_flush | ~rst_n;
    start_s = div_valid;
    if (start_s) begin
      m_a      = div_dividend;
      m_b      = div_divisor;
      m_signed = div_signed;
    end
    if (fire_s) begin
      checkOutput("div_dividend_held", div_dividend, m_a);
      checkOutput("div_divisor_held", div_divisor, m_b);
    end
    @(posedge clk);
    #1;
    if (kill_s || fire_s) begin
      div_o_valid = 1'b0;
      m_busy      = 1'b0;
    end
    if (start_s && !kill_s) begin
      m_busy  = 1'b1;
      m_count = div_latency;
    end else if (m_busy && !div_o_valid) begin
      if (m_count > 0) begin
        m_count--;
      end else begin
        if (m_b == 64'd0) begin
          div_quotient  = '1;
          div_remainder = m_a;
        end else if (m_signed) begin
          div_quotient  = 64'($signed(m_a) / $signed(m_b));
          div_remainder = 64'($signed(m_a) % $signed(m_b));
        end else begin
          div_quotient  = m_a / m_b;
          div_remainder = m_a % m_b;
        end
        div_o_valid = 1'b1;
      end
    end
  end

  // Presents one operation, waits (bounded) for acceptance, and checks
  // out_valid on the cycle after acceptance (high only for bypass cases).
  task automatic applyStimulus(input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic is_rem, input logic is_unsigned,
                               input logic is_word, input logic [TAG_W-1:0] tg,
                               input logic [63:0] expected, input logic bypass,
                               input logic push);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid       = 1'b1;
    in_rs1         = rs1;
    in_rs2         = rs2;
    in_is_rem      = is_rem;
    in_is_unsigned = is_unsigned;
    in_is_word     = is_word;
    in_tag         = tg;
    if (push) exp_q.push_back('{result: expected, tag: tg});
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("out_valid_after_accept", 64'(out_valid), 64'(bypass));
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d pending results expected 0", name, exp_q.size());
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 500000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int base;
    int n;
    int seen;
    rst_n          = 1'b0;
    flush          = 1'b0;
    in_valid       = 1'b0;
    in_rs1         = '0;
    in_rs2         = '0;
    in_is_rem      = 1'b0;
    in_is_unsigned = 1'b0;
    in_is_word     = 1'b0;
    in_tag         = '0;
    out_ready      = 1'b1;
    div_o_valid    = 1'b0;
    div_quotient   = '0;
    div_remainder  = '0;
    m_busy         = 1'b0;
    m_count        = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_result", out_result, 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset_div_valid", 64'(div_valid), 64'd0);
    checkOutput("reset_div_signed", 64'(div_signed), 64'd0);
    checkOutput("reset_div_dividend", div_dividend, 64'd0);
    checkOutput("reset_div_divisor", div_divisor, 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // DIV / REM -7 by 2 through the divider
    base = div_valid_pulses;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b0, 1'b0, 5'd1,
                  64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1);
    checkOutput("div_signed_div", 64'(div_signed), 64'd1);
    waitDone("div_neg7");
    checkOutput("div_valid_pulses_div", 64'(div_valid_pulses - base), 64'd1);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 5'd2,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    waitDone("rem_neg7");

    // Divide by zero and signed overflow: bypassed, divider untouched
    base = div_valid_pulses;
    applyStimulus(64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    waitDone("divu_zero");
    applyStimulus(64'd5, 64'd0, 1'b1, 1'b1, 1'b0, 5'd4, 64'd5, 1'b1, 1'b1);
    waitDone("remu_zero");
    applyStimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd5,
                  64'h8000_0000_0000_0000, 1'b1, 1'b1);
    waitDone("div_ovf");
    applyStimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd6,
                  64'd0, 1'b1, 1'b1);
    waitDone("rem_ovf");
    applyStimulus(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd7,
                  64'hFFFF_FFFF_8000_0000, 1'b1, 1'b1);
    waitDone("divw_ovf");
    checkOutput("div_valid_pulses_special", 64'(div_valid_pulses - base), 64'd0);

    // W variants: operand extension and result sign extension
    applyStimulus(64'h1234_5678_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 1'b1, 5'd8,
                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    checkOutput("div_dividend_uw", div_dividend, 64'h0000_0000_FFFF_FFFE);
    checkOutput("div_signed_uw", 64'(div_signed), 64'd0);
    checkOutput("div_valid_issue", 64'(div_valid), 64'd1);
    waitDone("divuw");
    applyStimulus(64'hAAAA_AAAA_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1, 5'd9,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    waitDone("remw");

    // Flush ten cycles into WAIT; the killed op must never write back
    div_latency = 30;
    base = div_valid_pulses;
    applyStimulus(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 5'd10, 64'd0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_div_flush", 64'(div_flush), 64'd1);
    checkOutput("flush_div_o_ready", 64'(div_o_ready), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("post_flush_in_ready", 64'(in_ready), 64'd1);
    checkOutput("post_flush_div_flush", 64'(div_flush), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("post_flush_out_valid_seen", 64'(seen), 64'd0);
    checkOutput("div_valid_pulses_flush", 64'(div_valid_pulses - base), 64'd1);
    div_latency = 3;
    applyStimulus(64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 5'd11, 64'd14, 1'b0, 1'b1);
    waitDone("divu_after_flush");

    // Back-pressure in DONE: result and tag held, no new acceptance
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(64'd1000, 64'd10, 1'b0, 1'b0, 1'b0, 5'd12, 64'd100, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("hold_out_valid_rise", 64'(out_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      checkOutput("hold_out_result", out_result, 64'd100);
      checkOutput("hold_out_tag", 64'(out_tag), 64'd12);
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("release_out_valid", 64'(out_valid), 64'd0);
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
